// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, load funct code and memory-stage FSM states
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int REG_W  = 3;

  localparam logic [4:0] FUNCT_LD = 5'h10;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - 256x8 single-port synchronous RAM, write-first read
module data_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write-first: a write returns the new data on the read port in the same cycle
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory stage and MEM/WB register; optional DISPLAY_MMIO_EN display latch
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        funct,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] memWriteData,
  input  logic [REG_W-1:0]  targetReg,
  input  logic              regWrite,
  input  logic              memReadWrite,
  output logic [DATA_W-1:0] wbData_o,
  output logic [REG_W-1:0]  wbReg_o,
  output logic              wbEnable_o,
  output logic              fwdValid_o,
  output logic              stall_o
`ifdef DISPLAY_MMIO_EN
  ,
  output logic [DATA_W-1:0] display_o
`endif
);

  mem_state_t        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_stall;
  logic              r_is_load;
  logic [DATA_W-1:0] r_alu_res;
  logic [REG_W-1:0]  r_wb_reg;
  logic              r_wb_en;

  logic              w_clearing;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  // RAM port is owned by the clear counter during CLEAR; a store coinciding with reset is dropped
  assign w_clearing  = (r_state == CLEAR);
  assign w_ram_we    = rst_n & (w_clearing | memReadWrite);
  assign w_ram_addr  = w_clearing ? r_clr_addr : memAddr;
  assign w_ram_wdata = w_clearing ? '0 : memWriteData;

  data_ram #(
    .DEPTH(DEPTH)
  ) u_data_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  // Clear/run FSM together with the MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= (INIT_CLEAR != 0) ? CLEAR : RUN;
      r_clr_addr <= '0;
      r_stall    <= (INIT_CLEAR != 0);
      r_is_load  <= 1'b0;
      r_alu_res  <= '0;
      r_wb_reg   <= '0;
      r_wb_en    <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 8'd1;
          r_is_load  <= 1'b0;
          r_alu_res  <= '0;
          r_wb_reg   <= '0;
          r_wb_en    <= 1'b0;
          if (r_clr_addr == 8'hFF) begin
            r_state <= RUN;
            r_stall <= 1'b0;
          end
        end
        RUN: begin
          r_is_load <= (funct == FUNCT_LD);
          r_alu_res <= ALUresult;
          r_wb_reg  <= targetReg;
          r_wb_en   <= regWrite;
        end
        default: begin
          r_state <= RUN;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

`ifdef DISPLAY_MMIO_EN
  logic [DATA_W-1:0] r_display;

  // Stores to the top address also latch the display; clearing the RAM leaves it alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_display <= '0;
    end else if (!w_clearing && memReadWrite && memAddr == 8'hFF) begin
      r_display <= memWriteData;
    end
  end

  assign display_o = r_display;
`endif

  assign wbData_o   = r_is_load ? w_ram_rdata : r_alu_res;
  assign wbReg_o    = r_wb_reg;
  assign wbEnable_o = r_wb_en & ~r_stall;
  assign fwdValid_o = wbEnable_o;
  assign stall_o    = r_stall;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - vector table, corner sequences and random model check of mem_wb_stage
module tb_mem_wb_stage;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] funct;
  logic [7:0] memAddr, ALUresult, memWriteData;
  logic [2:0] targetReg;
  logic       regWrite, memReadWrite;
  logic [7:0] wbData_o;
  logic [2:0] wbReg_o;
  logic       wbEnable_o, fwdValid_o, stall_o;
`ifdef DISPLAY_MMIO_EN
  logic [7:0] display_o;
`endif

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(256), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst_n(rst_n), .funct(funct), .memAddr(memAddr),
    .ALUresult(ALUresult), .memWriteData(memWriteData), .targetReg(targetReg),
    .regWrite(regWrite), .memReadWrite(memReadWrite),
    .wbData_o(wbData_o), .wbReg_o(wbReg_o), .wbEnable_o(wbEnable_o),
    .fwdValid_o(fwdValid_o), .stall_o(stall_o)
`ifdef DISPLAY_MMIO_EN
    , .display_o(display_o)
`endif
  );

  typedef struct {
    logic       we;
    logic [4:0] f;
    logic [7:0] a;
    logic [7:0] alu;
    logic [7:0] wd;
    logic [2:0] tr;
    logic       rw;
    logic [7:0] e_data;
    logic [2:0] e_reg;
    logic       e_en;
  } vec_t;

  vec_t       tbl[9];
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] model_mem [256];
  logic [7:0] model_disp = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
  endtask

  task automatic zero_inputs();
    funct = '0; memAddr = '0; ALUresult = '0; memWriteData = '0;
    targetReg = '0; regWrite = 1'b0; memReadWrite = 1'b0;
  endtask

  // Apply one op for one edge and keep the reference memory image up to date
  task automatic drive(input logic we, input logic [4:0] f, input logic [7:0] a,
                       input logic [7:0] alu, input logic [7:0] wd,
                       input logic [2:0] tr, input logic rw);
    memReadWrite = we; funct = f; memAddr = a; ALUresult = alu;
    memWriteData = wd; targetReg = tr; regWrite = rw;
    step();
    if (we) begin
      model_mem[a] = wd;
      if (a == 8'hFF) model_disp = wd;
    end
  endtask

  // Count stall cycles after reset release while feeding inputs that must be ignored
  task automatic wait_clear(input string name);
    int cnt = 0;
    int en_bad = 0;
    memReadWrite = 1'b1; memAddr = 8'h55; memWriteData = 8'hEE;
    regWrite = 1'b1; funct = FUNCT_LD; ALUresult = 8'h99; targetReg = 3'd6;
    while (stall_o && cnt < 1000) begin
      if (wbEnable_o) en_bad++;
      step();
      cnt++;
    end
    zero_inputs();
    chk(name, cnt, 256);
    chk({name, "_wben"}, en_bad, 0);
    clear_model();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_data"}, wbData_o, 0);
    chk({name, "_reg"}, wbReg_o, 0);
    chk({name, "_en"}, wbEnable_o, 0);
    chk({name, "_fwd"}, fwdValid_o, 0);
    chk({name, "_stall"}, stall_o, 1);
`ifdef DISPLAY_MMIO_EN
    chk({name, "_disp"}, display_o, 0);
`endif
  endtask

  initial begin
    logic [7:0] exp_data;
    logic       we, ld, rw;
    logic [4:0] f;
    logic [7:0] a, alu, wd;
    logic [2:0] tr;

    tbl[0] = '{1'b1, 5'h00,    8'h10, 8'h12, 8'hA5, 3'd1, 1'b0, 8'h12, 3'd1, 1'b0};
    tbl[1] = '{1'b0, FUNCT_LD, 8'h10, 8'h00, 8'h00, 3'd3, 1'b1, 8'hA5, 3'd3, 1'b1};
    tbl[2] = '{1'b0, 5'h01,    8'h00, 8'h7E, 8'h00, 3'd5, 1'b1, 8'h7E, 3'd5, 1'b1};
    tbl[3] = '{1'b0, 5'h00,    8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[4] = '{1'b0, FUNCT_LD, 8'h00, 8'h00, 8'h00, 3'd2, 1'b1, 8'h00, 3'd2, 1'b1};
    tbl[5] = '{1'b1, FUNCT_LD, 8'h40, 8'h00, 8'h5A, 3'd4, 1'b1, 8'h5A, 3'd4, 1'b1};
    tbl[6] = '{1'b0, FUNCT_LD, 8'h40, 8'h00, 8'h00, 3'd1, 1'b1, 8'h5A, 3'd1, 1'b1};
    tbl[7] = '{1'b1, 5'h02,    8'hFF, 8'h01, 8'h3C, 3'd0, 1'b0, 8'h01, 3'd0, 1'b0};
    tbl[8] = '{1'b0, FUNCT_LD, 8'hFF, 8'h00, 8'h00, 3'd7, 1'b1, 8'h3C, 3'd7, 1'b1};

    rst_n = 1'b0;
    zero_inputs();
    clear_model();
    step();
    step();
    chk_reset_outputs("reset");

    rst_n = 1'b1;
    wait_clear("init_clear_cycles");

    drive(1'b0, FUNCT_LD, 8'h37, 8'h00, 8'h00, 3'd2, 1'b1);
    chk("load_0x37_after_clear", wbData_o, 0);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].f, tbl[i].a, tbl[i].alu, tbl[i].wd, tbl[i].tr, tbl[i].rw);
      chk($sformatf("vec%0d_data", i), wbData_o, tbl[i].e_data);
      chk($sformatf("vec%0d_reg", i), wbReg_o, tbl[i].e_reg);
      chk($sformatf("vec%0d_en", i), wbEnable_o, tbl[i].e_en);
      chk($sformatf("vec%0d_fwd", i), fwdValid_o, tbl[i].e_en);
    end
`ifdef DISPLAY_MMIO_EN
    chk("display_after_ff_store", display_o, 8'h3C);
`endif

    for (int i = 0; i < 150; i++) begin
      we  = ($urandom_range(0, 2) == 0);
      ld  = ($urandom_range(0, 1) == 1);
      f   = 5'($urandom);
      if (ld) f = FUNCT_LD;
      else if (f == FUNCT_LD) f = f ^ 5'h01;
      a   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      alu = 8'($urandom);
      wd  = 8'($urandom);
      tr  = 3'($urandom);
      rw  = 1'($urandom);
      drive(we, f, a, alu, wd, tr, rw);
      exp_data = ld ? model_mem[a] : alu;
      chk($sformatf("rand%0d_data", i), wbData_o, exp_data);
      chk($sformatf("rand%0d_reg", i), wbReg_o, tr);
      chk($sformatf("rand%0d_en", i), wbEnable_o, rw);
`ifdef DISPLAY_MMIO_EN
      chk($sformatf("rand%0d_disp", i), display_o, model_disp);
`endif
    end

    drive(1'b1, 5'h00, 8'h20, 8'h00, 8'h55, 3'd0, 1'b0);
    drive(1'b1, 5'h00, 8'hFF, 8'h00, 8'h66, 3'd0, 1'b0);
    drive(1'b0, 5'h01, 8'h00, 8'h7E, 8'h00, 3'd5, 1'b1);
    chk("pre_reset_fwd", fwdValid_o, 1);
    memReadWrite = 1'b1; memAddr = 8'h21; memWriteData = 8'h77;
    funct = 5'h00; regWrite = 1'b1; ALUresult = 8'h44; targetReg = 3'd3;
    rst_n = 1'b0;
    step();
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    model_disp = 8'h00;
    wait_clear("reclear_cycles");
    drive(1'b0, FUNCT_LD, 8'h20, 8'h00, 8'h00, 3'd1, 1'b1);
    chk("reclear_load_0x20", wbData_o, 0);
    drive(1'b0, FUNCT_LD, 8'h21, 8'h00, 8'h00, 3'd1, 1'b1);
    chk("dropped_store_0x21", wbData_o, 0);
    drive(1'b0, FUNCT_LD, 8'hFF, 8'h00, 8'h00, 3'd1, 1'b1);
    chk("reclear_load_0xff", wbData_o, 0);
`ifdef DISPLAY_MMIO_EN
    chk("display_after_reset", display_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory stage plus MEM/WB pipeline register of the 8-bit pipelined processor. Consumes the EX/MEM register outputs, performs data-memory loads and stores against a 256×8 synchronous RAM, and presents writeback data, destination register and write enable to the register file. It also drives a forwarding tap back to EX and a stall request while the RAM is being cleared after reset.

## Interface
- Parameters:
- `DEPTH`, 256, data-memory words. Must equal 2^8.
- `INIT_CLEAR`, 1, when 1 the RAM is zero-filled after reset.
- Ports:
- `clk`  in  1  sole clock, all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `funct`  in  5  opcode/funct from EX/MEM.
- `memAddr`  in  8  data-memory address.
- `ALUresult`  in  8  ALU output.
- `memWriteData`  in  8  store data.
- `targetReg`  in  3  destination register.
- `regWrite`  in  1  register-write enable.
- `memReadWrite`  in  1  1 = store, 0 = no store.
- `wbData_o`  out  8  writeback data.
- `wbReg_o`  out  3  writeback destination.
- `wbEnable_o`  out  1  register-file write enable.
- `fwdValid_o`  out  1  forwarding tap valid, equal to `wbEnable_o`.
- `stall_o`  out  1  upstream must hold while high.
- `display_o`  out  8  display latch (only with `DISPLAY_MMIO_EN`).

## Operation
- FSM with two states: `CLEAR` and `RUN`. Reset enters `CLEAR` if `INIT_CLEAR`=1, otherwise `RUN`.
- `CLEAR`:
  - 8-bit counter `clrAddr` starts at 0 and writes 0x00 to RAM[clrAddr] each cycle.
  - After address 0xFF is written, the FSM moves to `RUN`.
  - `stall_o`=1 for the whole state; all EX/MEM inputs are ignored.
- `RUN`:
  - Store: when `memReadWrite`=1, RAM[memAddr] <= memWriteData at posedge.
  - Load: when `funct`==`FUNCT_LD`, RAM[memAddr] is read synchronously, and the registered flag `isLoad_q` selects RAM output for writeback.
  - Non-load: `ALUresult` is registered into `aluRes_q`.
  - `wbData_o` = isLoad_q ? ramRdata : aluRes_q.
- Read/write collision on the same address in the same cycle: read returns the new data (write-first).
- `memReadWrite`=1 together with `FUNCT_LD` is illegal. The store takes effect and the load returns the stored value.
- An all-zero bundle from a flushed EX/MEM is a bubble: no store, and no writeback because `regWrite`=0.
- Reset asserted mid-operation (in any state):
  - Outputs return to reset values next cycle.
  - An in-flight store is dropped if its posedge coincides with reset low.
  - RAM contents are cleared again by `CLEAR`.

## Timing
- Reset values: `wbData_o`=0, `wbReg_o`=0, `wbEnable_o`=0, `fwdValid_o`=0, `display_o`=0. `stall_o`=1 (`INIT_CLEAR`=1) or 0 (`INIT_CLEAR`=0).
- Latency is 1 cycle for every path: inputs sampled at edge N appear on `wb*_o` after edge N.
- `stall_o` is registered. With `INIT_CLEAR`=1 it is high for exactly 256 cycles after reset deassertion, falls after the edge that writes 0xFF, and rises on the first edge with `rst_n`=0.
- `wbEnable_o` is forced to 0 while `stall_o`=1.

## Configuration
- Macro `DISPLAY_MMIO_EN`.
- Defined:
  - A store to address 0xFF also loads `display_o` at the same edge.
  - RAM[0xFF] is still written.
  - `display_o` is cleared by reset and unaffected by `CLEAR`.
- Undefined: the `display_o` port and its register are absent, and address 0xFF is ordinary memory.

## Structure
- The shared package `cpu_pkg` holds:
  - the `FUNCT_LD` constant;
  - the `ADDR_W`=8, `DATA_W`=8 and `REG_W`=3 width constants;
  - the FSM state enum `mem_state_t` {`CLEAR`, `RUN`}.
- One sub-module: `data_ram`, a 256×8 single-port synchronous RAM with write-first behaviour. The FSM, clear counter, MEM/WB register and display latch stay in `mem_wb_stage`.

## Test plan
- Reset release with `INIT_CLEAR`=1 -> `stall_o` high for 256 cycles then 0. A load from 0x37 afterwards returns `wbData_o`=0x00.
- Store 0xA5 to 0x10, then load 0x10 with `targetReg`=3 -> one cycle later `wbData_o`=0xA5, `wbReg_o`=3, `wbEnable_o`=1.
- ALU op with `ALUresult`=0x7E, `targetReg`=5, `regWrite`=1 -> next cycle `wbData_o`=0x7E, `wbReg_o`=5, `fwdValid_o`=1.
- Bubble (all inputs 0) after a valid op -> `wbEnable_o`=0 and no RAM change at address 0.
- Store 0x3C to 0xFF with `DISPLAY_MMIO_EN` -> `display_o`=0x3C next cycle. Without the macro, a subsequent load from 0xFF returns 0x3C.
- `rst_n` low for one cycle during a store stream -> that store is not written, outputs go to 0 and `stall_o`=1, and a 256-cycle clear follows.
